// File: rtl/npu_pkg.sv
// Shared NPU definitions: default layer widths, streaming FSM state type and
// the index-width helper used by loaders and serializers.
package npu_pkg;

   localparam int DEFAULT_OUT_N      = 4;
   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } stream_state_t;

   // Never returns 0, so a single-element vector still gets a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/signed_max_sel.sv
// Selects the larger of two signed (value, index) pairs. Pair a always carries
// the lower index, so b must be strictly greater to win and ties keep a.
module signed_max_sel #(
   parameter int DATA_WIDTH = 8,
   parameter int IDX_WIDTH  = 2
) (
   input  logic                         a_valid,
   input  logic signed [DATA_WIDTH-1:0] a_val,
   input  logic        [IDX_WIDTH-1:0]  a_idx,
   input  logic signed [DATA_WIDTH-1:0] b_val,
   input  logic        [IDX_WIDTH-1:0]  b_idx,
   output logic signed [DATA_WIDTH-1:0] max_val,
   output logic        [IDX_WIDTH-1:0]  max_idx
);

   logic take_b;

   // An invalid a (nothing seen yet) always yields to b.
   assign take_b  = !a_valid || (b_val > a_val);
   assign max_val = take_b ? b_val : a_val;
   assign max_idx = take_b ? b_idx : a_idx;

endmodule

// File: rtl/layer_out_serializer.sv
// Streams a captured layer output vector one signed element per beat, tracking
// a running signed max/argmax so the classification result rides on the last beat.
module layer_out_serializer
   import npu_pkg::*;
#(
   parameter int OUT_N      = DEFAULT_OUT_N,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int IDX_WIDTH  = idx_width(OUT_N)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [OUT_N*DATA_WIDTH-1:0] in_vec,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic [IDX_WIDTH-1:0]        out_idx,
   output logic                        out_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_max,
   output logic [IDX_WIDTH-1:0]        out_argmax
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OUT_N - 1);

   stream_state_t                        state_q, state_d;
   logic [OUT_N-1:0][DATA_WIDTH-1:0]     vec_q;
   logic [IDX_WIDTH-1:0]                 idx_q;
   logic signed [DATA_WIDTH-1:0]         run_max_q;
   logic [IDX_WIDTH-1:0]                 run_arg_q;
   logic                                 run_valid_q;

   logic                                 fire;
   logic                                 is_last;
   logic                                 capture;
   logic signed [DATA_WIDTH-1:0]         cur_val;
   logic signed [DATA_WIDTH-1:0]         merged_max;
   logic [IDX_WIDTH-1:0]                 merged_arg;

   assign cur_val = vec_q[idx_q];

   // The merge of running state with the current element feeds both the
   // running-max register and the out_max/out_argmax outputs.
   signed_max_sel #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_max_sel (
      .a_valid (run_valid_q),
      .a_val   (run_max_q),
      .a_idx   (run_arg_q),
      .b_val   (cur_val),
      .b_idx   (idx_q),
      .max_val (merged_max),
      .max_idx (merged_arg)
   );

   // Handshakes: a transfer happens on a cycle where valid and ready are both
   // high; valid never waits on ready, and outputs hold while valid && !ready.
   always_comb begin
      state_d   = state_q;
      out_valid = (state_q == STREAM);
      is_last   = (idx_q == LAST_IDX);
      fire      = out_valid && out_ready;
      out_last  = out_valid && is_last;
      in_ready  = (state_q == IDLE) || (fire && is_last);
      capture   = in_valid && in_ready;
      case (state_q)
         IDLE:    if (in_valid) state_d = STREAM;
         STREAM:  if (fire && is_last && !in_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_q       <= '0;
         idx_q       <= '0;
         run_max_q   <= '0;
         run_arg_q   <= '0;
         run_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            vec_q       <= in_vec;
            idx_q       <= '0;
            run_valid_q <= 1'b0;
         end else if (fire && !is_last) begin
            idx_q       <= idx_q + 1'b1;
            run_max_q   <= merged_max;
            run_arg_q   <= merged_arg;
            run_valid_q <= 1'b1;
         end
      end
   end

   assign out_data   = cur_val;
   assign out_idx    = idx_q;
   assign out_max    = merged_max;
   assign out_argmax = merged_arg;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed and randomized checks of layer_out_serializer (OUT_N=4 and OUT_N=1)
// against a lane-list / max-scan reference model.
module tb_layer_out_serializer;

   logic        clk;
   logic        rst_n;

   logic [31:0] in_vec;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_idx;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_max;
   logic [1:0]  out_argmax;

   logic [7:0]  in_vec1;
   logic        in_valid1;
   logic        in_ready1;
   logic [7:0]  out_data1;
   logic [0:0]  out_idx1;
   logic        out_last1;
   logic        out_valid1;
   logic        out_ready1;
   logic [7:0]  out_max1;
   logic [0:0]  out_argmax1;

   int total = 0;
   int bad   = 0;
   int busy;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] idx;
      logic       last;
      logic [7:0] mx;
      logic [1:0] am;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] vq[$];

   layer_out_serializer #(.OUT_N(4), .DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_vec     (in_vec),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .out_last   (out_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_max    (out_max),
      .out_argmax (out_argmax)
   );

   layer_out_serializer #(.OUT_N(1), .DATA_WIDTH(8)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_vec     (in_vec1),
      .in_valid   (in_valid1),
      .in_ready   (in_ready1),
      .out_data   (out_data1),
      .out_idx    (out_idx1),
      .out_last   (out_last1),
      .out_valid  (out_valid1),
      .out_ready  (out_ready1),
      .out_max    (out_max1),
      .out_argmax (out_argmax1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: the beats are the lanes in order; max/argmax is a plain scan
   // keeping the first occurrence of the largest signed value.
   task automatic push_vector(input logic [31:0] v);
      logic signed [7:0] lane [4];
      int best;
      int arg;
      for (int i = 0; i < 4; i++) lane[i] = v[i*8 +: 8];
      best = int'(lane[0]);
      arg  = 0;
      for (int i = 1; i < 4; i++) begin
         if (int'(lane[i]) > best) begin
            best = int'(lane[i]);
            arg  = i;
         end
      end
      for (int i = 0; i < 4; i++) begin
         beat_t b;
         b.data = lane[i];
         b.idx  = 2'(i);
         b.last = (i == 3);
         b.mx   = 8'(best);
         b.am   = 2'(arg);
         exp_q.push_back(b);
      end
   endtask

   // Offers every vector in vq back to back and consumes beats, checking
   // each cycle. stall_beat/stall_len force out_ready low on that beat.
   task automatic run_seq(input int stall_pct, input int stall_beat, input int stall_len,
                          output int busy_cycles);
      int   vi   = 0;
      int   cyc  = 0;
      int   held = 0;
      logic exp_rdy;
      busy_cycles = 0;
      while ((vi < vq.size() || exp_q.size() > 0) && cyc < 300) begin
         @(posedge clk);
         #1;
         in_valid = (vi < vq.size());
         if (vi < vq.size()) in_vec = vq[vi];
         if (exp_q.size() > 0 && int'(exp_q[0].idx) == stall_beat && held < stall_len) begin
            out_ready = 1'b0;
            held++;
         end else begin
            out_ready = ($urandom_range(99) >= stall_pct);
         end
         @(negedge clk);
         cyc++;
         chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
         exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q[0].last);
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
         if (exp_q.size() > 0) begin
            busy_cycles++;
            chk("out_data", 32'(out_data), 32'(exp_q[0].data));
            chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
            chk("out_last", 32'(out_last), 32'(exp_q[0].last));
            if (exp_q[0].last) begin
               chk("out_max", 32'(out_max), 32'(exp_q[0].mx));
               chk("out_argmax", 32'(out_argmax), 32'(exp_q[0].am));
            end
            if (out_ready) void'(exp_q.pop_front());
         end
         if (in_valid && exp_rdy) begin
            push_vector(vq[vi]);
            vi++;
         end
      end
      chk("seq_timeout", 32'(cyc < 300), 32'd1);
      in_valid = 1'b0;
      exp_q.delete();
      vq.delete();
   endtask

   initial begin
      rst_n      = 1'b0;
      in_vec     = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      in_vec1    = '0;
      in_valid1  = 1'b0;
      out_ready1 = 1'b0;

      // Reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      chk("rst_out_max", 32'(out_max), 32'd0);
      chk("rst_out_argmax", 32'(out_argmax), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // Basic drain with out_ready held high
      vq.push_back(32'h807FFD05);
      run_seq(0, -1, 0, busy);
      chk("basic_drain", 32'(busy), 32'd4);

      // Backpressure on beat 1 for 3 cycles
      vq.push_back(32'h807FFD05);
      run_seq(0, 1, 3, busy);
      chk("stall_drain", 32'(busy), 32'd7);

      // Back-to-back vectors
      vq.push_back(32'h807FFD05);
      vq.push_back(32'h04030201);
      run_seq(0, -1, 0, busy);
      chk("b2b_drain", 32'(busy), 32'd8);

      // Ties and negatives
      vq.push_back(32'h07FF0707);
      vq.push_back(32'hFEF7FEFB);
      run_seq(0, -1, 0, busy);

      // Reset mid-stream after beat 1 fires
      @(posedge clk);
      #1;
      in_vec    = 32'h807FFD05;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_beat0", 32'(out_idx), 32'd0);
      @(negedge clk);
      chk("mid_beat1", 32'(out_data), 32'hFD);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_out_last", 32'(out_last), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      vq.push_back(32'h00000009);
      run_seq(0, -1, 0, busy);

      // Randomized traffic with random backpressure
      repeat (15) begin
         int n;
         n = $urandom_range(1, 3);
         for (int k = 0; k < n; k++) vq.push_back($urandom);
         run_seq(30, -1, 0, busy);
      end

      // Single-element instance
      @(posedge clk);
      #1;
      in_vec1    = 8'h81;
      in_valid1  = 1'b1;
      out_ready1 = 1'b1;
      @(negedge clk);
      chk("n1_in_ready_idle", 32'(in_ready1), 32'd1);
      chk("n1_idle_valid", 32'(out_valid1), 32'd0);
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      @(negedge clk);
      chk("n1_out_valid", 32'(out_valid1), 32'd1);
      chk("n1_out_data", 32'(out_data1), 32'h81);
      chk("n1_out_idx", 32'(out_idx1), 32'd0);
      chk("n1_out_last", 32'(out_last1), 32'd1);
      chk("n1_out_max", 32'(out_max1), 32'h81);
      chk("n1_out_argmax", 32'(out_argmax1), 32'd0);
      chk("n1_in_ready_last", 32'(in_ready1), 32'd1);
      @(negedge clk);
      chk("n1_drained", 32'(out_valid1), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/layer_out_serializer.md
Name: layer_out_serializer

Overview:
Drains the packed output vector of a Layer instance and streams it out one signed element per beat over a valid/ready interface. Tracks a running signed maximum and its index, so a classification argmax is available on the final beat. Sits between a Layer's out_vec and any narrow downstream consumer (next-layer loader, host readback FIFO). Accepting a whole vector is a valid/ready handshake with the producer.

Parameters:
OUT_N, 4, number of elements per vector (>=1)
DATA_WIDTH, 8, signed element width in bits
IDX_WIDTH, (OUT_N>1 ? $clog2(OUT_N) : 1), element index width (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, active-low
in_vec  input  OUT_N*DATA_WIDTH  packed vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_valid  input  1  in_vec is valid
in_ready  output  1  block can capture in_vec this cycle
out_data  output  DATA_WIDTH  current signed element
out_idx  output  IDX_WIDTH  lane index of out_data
out_last  output  1  out_data is lane OUT_N-1
out_valid  output  1  out_data/out_idx/out_last are valid
out_ready  input  1  consumer accepts the current beat
out_max  output  DATA_WIDTH  signed maximum over the vector; valid when out_valid && out_last
out_argmax  output  IDX_WIDTH  lane of out_max; valid when out_valid && out_last

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low, on ports clk and rst_n.
- Reset values: state=IDLE, out_valid=0, idx=0, vector buffer=0, out_data=0, out_idx=0, out_last=0 (asserted only while out_valid), running max=0, running argmax=0. in_ready=1 once rst_n is deasserted.
- FSM states are IDLE and STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid is high, capture in_vec into the buffer, set idx=0, clear the running-max-valid flag, and go to STREAM.
- STREAM:
  - out_valid=1. out_data=buffer lane idx. out_idx=idx. out_last=(idx==OUT_N-1).
  - A beat fires when out_valid && out_ready. On a fire with idx<OUT_N-1: idx increments and the running max/argmax updates with the current element.
- Running max:
  - Signed comparison with strict greater-than, so ties keep the lowest index.
  - The first element always loads.
- out_max/out_argmax:
  - Combinational: the running value merged with the current element, using the same rule.
  - On the last beat they reflect all OUT_N elements.
- Stall: while out_valid && !out_ready, every out_* signal holds stable. Nothing is dropped.
- Last beat: in_ready = out_valid && out_ready && out_last. This is the only combinational path from out_ready to in_ready.
  - Last fires with in_valid=1: the new vector is captured, idx=0, state stays STREAM, out_valid stays 1. There is zero bubble between vectors.
  - Last fires with in_valid=0: go to IDLE, out_valid=0 next cycle.
- in_vec captured while in STREAM before the last beat: impossible, because in_ready=0. The producer must hold the vector.
- OUT_N=1: every beat is last, out_idx=0, out_argmax=0, out_max=out_data.
- Latency: in accept at cycle N gives first out_valid at cycle N+1. With out_ready held high, a vector drains in OUT_N cycles, and throughput is one vector per OUT_N cycles.
- Reset mid-stream: out_valid drops to 0 asynchronously, and the partially streamed vector is discarded. After release the block is in IDLE with in_ready=1.
- Width: no arithmetic widening. All elements are compared as signed DATA_WIDTH values.

Decomposition:
- Shared package npu_pkg holds:
  - stream_state_t enum {IDLE, STREAM}.
  - Function idx_width(n), returning max(1, $clog2(n)), reused by future loaders and serializers.
- DATA_WIDTH and OUT_N defaults come from the existing width header.
- One natural sub-module is signed_max_sel: combinational compare/select of (value, index) pairs with tie-to-lower-index. It is reused for the running update and for the out_max/out_argmax merge.
- FSM, counter and buffer stay in the top module.

Test Plan:
All scenarios use DATA_WIDTH=8, OUT_N=4.
1. Basic: in_vec lanes {5,-3,127,-128}, out_ready=1 -> beats 0x05,0xFD,0x7F,0x80 on consecutive cycles starting the cycle after accept; out_last only on beat 3; there out_max=127, out_argmax=2; then out_valid=0 and in_ready=1.
2. Backpressure: same vector, out_ready low for 3 cycles during beat 1 -> out_data=0xFD, out_idx=1 held all 3 cycles; total drain 7 cycles; no duplicate or skipped beats.
3. Back-to-back: second vector {1,2,3,4} held with in_valid during the first stream -> in_ready pulses only on the last-beat cycle; the next cycle shows out_data=1, out_idx=0 with no bubble; second out_argmax=3, out_max=4.
4. Ties and negatives: {7,7,-1,7} -> out_argmax=0, out_max=7. {-5,-2,-9,-2} -> out_argmax=1, out_max=-2 (0xFE).
5. Reset mid-stream: assert rst_n=0 after beat 1 fires -> out_valid=0 within the same cycle (async); after release, in_ready=1, and a new vector {9,0,0,0} streams from idx 0 with out_argmax=0.
6. OUT_N=1 instance: in_vec=0x81 -> single beat with out_last=1, out_max=-127, out_argmax=0.
